demux_scan_ctrl: RTL and testbench
==================================

DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 32, number of demux outputs; the only supported value is 32.
REQ-002 SHALL have parameter DWELL_W, default 4, width of the dwell field.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; there SHALL be no other clock or reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  scan request; accepted only when ready_o=1.
REQ-007 mask_i  input  32  channels to visit; bit n = channel n.
REQ-008 data_i  input  1  bit to drive on each visited channel.
REQ-009 dwell_i  input  DWELL_W  cycles per channel, minus 1 (0..15 means 1..16 cycles).
REQ-010 abort_i  input  1  terminates an active scan.
REQ-011 ready_o  output  1  idle and able to accept start_i.
REQ-012 busy_o  output  1  scan in progress.
REQ-013 done_o  output  1  single-cycle pulse when a scan completes normally.
REQ-014 ch_o  output  5  channel currently driven; 0 when not scanning.
REQ-015 out_o  output  32  demux output vector.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 IDLE: ready_o=1, busy_o=0, the demux enable is 0 and out_o=0.
REQ-018 In IDLE with start_i=1, SHALL latch mask_i, data_i and dwell_i into the pending-mask, data and dwell registers.
- Next state is SCAN if mask_i≠0.
- Next state is DONE if mask_i=0.
REQ-019 SCAN: busy_o=1, ready_o=0, demux en=1, sel = lowest set bit of the pending mask, demux data = latched data.
REQ-020 SCAN dwell counter:
- Starts at 0 on each new channel.
- Increments every cycle.
- When it equals the latched dwell, the current bit is cleared from the pending mask and the counter returns to 0.
REQ-021 When the cleared bit was the last pending bit, next state SHALL be DONE; otherwise SCAN continues with the next-lowest set bit in the following cycle, with no gap cycle.
REQ-022 Latency: if start is accepted at edge k, the first channel SHALL appear on out_o in the cycle after edge k.
REQ-023 The SCAN duration SHALL be exactly popcount(mask)×(dwell+1) cycles.
REQ-024 DONE: done_o=1 for exactly one cycle, ready_o=0, busy_o=0, out_o=0; next state IDLE.
REQ-025 abort_i=1 in SCAN SHALL force the next state to IDLE, clear the pending mask and suppress done_o.
- abort_i has priority over dwell completion in the same cycle.
REQ-026 abort_i SHALL be ignored in IDLE and DONE.
REQ-027 start_i SHALL be ignored when ready_o=0; mask_i, data_i and dwell_i SHALL NOT affect an active scan.
REQ-028 With data=0, out_o SHALL be all-zero during SCAN; ch_o and busy_o still sequence normally.
REQ-029 out_o SHALL have at most one bit set in any cycle.

Reset
REQ-030 On rst_ni=0, SHALL immediately (asynchronously) enter IDLE with:
- pending mask, data, dwell and counter = 0;
- ready_o=1, busy_o=0, done_o=0, ch_o=0, out_o=0.
REQ-031 Reset asserted mid-scan SHALL abandon the scan with no done_o pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_ni deasserts.

Structure
REQ-033 A shared package SHALL hold NUM_CH, the 5-bit channel index width, and the FSM state enum (IDLE, SCAN, DONE).
REQ-034 SHALL instantiate exactly one existing demux_1to32 sub-module (en_i, data_i, sel_i, out_o), driven by the registered controller state.
REQ-035 The lowest-set-bit priority encoder SHALL be written inline.

Verification
REQ-036 Single channel: mask=0x0000_0040, data=1, dwell=0 -> out_o=0x0000_0040 for 1 cycle, ch_o=6; done_o pulses the next cycle.
REQ-037 Ordered scan: mask=0x8000_4002, data=1, dwell=2 -> channels 1, 14, 31 in that order, 3 cycles each, 9 SCAN cycles, then done_o.
REQ-038 Empty mask: mask=0, start -> no SCAN cycles, done_o the cycle after start, out_o stays 0.
REQ-039 Abort: mask=0xFFFF_FFFF, dwell=15, abort_i asserted on cycle 20 of SCAN -> IDLE next cycle, out_o=0, no done_o, ready_o=1.
REQ-040 Busy start: start_i pulsed with mask=0x1 during a mask=0xF scan -> ignored; only channels 0-3 are driven.
REQ-041 Reset mid-scan: rst_ni low during SCAN -> out_o=0 and ready_o=1 without waiting for a clock edge; no done_o pulse.

Source files
------------

// File: rtl/demux_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the demux scan controller.
package demux_scan_ctrl_pkg;

  localparam int unsigned NUM_CH = 32;
  localparam int unsigned CH_W   = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Scan request / status bus between a scan initiator and demux_scan_ctrl.
interface demux_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 4
);
  import demux_scan_ctrl_pkg::*;

  logic                start_i;
  logic [NUM_CH-1:0]   mask_i;
  logic                data_i;
  logic [DWELL_W-1:0]  dwell_i;
  logic                abort_i;
  logic                ready_o;
  logic                busy_o;
  logic                done_o;
  logic [CH_W-1:0]     ch_o;
  logic [NUM_CH-1:0]   out_o;

  modport master (
    output start_i, mask_i, data_i, dwell_i, abort_i,
    input  ready_o, busy_o, done_o, ch_o, out_o
  );

  modport slave (
    input  start_i, mask_i, data_i, dwell_i, abort_i,
    output ready_o, busy_o, done_o, ch_o, out_o
  );

endinterface

// File: rtl/demux_1to32.sv
// 1-to-32 demultiplexer: routes data_i to output sel_i when enabled, all others 0.
module demux_1to32 (
  input  logic        en_i,
  input  logic        data_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[sel_i] = data_i;
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scans the set bits of a channel mask in ascending order, driving one demux output
// per channel for a programmable dwell; supports abort and reports completion.
module demux_scan_ctrl #(
  parameter int unsigned NUM_CH  = demux_scan_ctrl_pkg::NUM_CH,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  demux_scan_ctrl_if.slave    bus
);
  import demux_scan_ctrl_pkg::*;

  state_e              state_q;
  logic [NUM_CH-1:0]   mask_q;
  logic                data_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  cnt_q;

  logic [CH_W-1:0]     sel;
  logic [NUM_CH-1:0]   mask_rest;
  logic                scan;

  // Lowest set bit of the pending mask selects the active channel.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel = CH_W'(i);
      end
    end
  end

  assign mask_rest = mask_q & (mask_q - {{(NUM_CH-1){1'b0}}, 1'b1});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mask_q  <= '0;
      data_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            mask_q  <= bus.mask_i;
            data_q  <= bus.data_i;
            dwell_q <= bus.dwell_i;
            cnt_q   <= '0;
            state_q <= (bus.mask_i != '0) ? StScan : StDone;
          end
        end
        StScan: begin
          // Abort wins over a dwell completion in the same cycle.
          if (bus.abort_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
            cnt_q   <= '0;
          end else if (cnt_q == dwell_q) begin
            mask_q <= mask_rest;
            cnt_q  <= '0;
            if (mask_rest == '0) begin
              state_q <= StDone;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign scan        = (state_q == StScan);
  assign bus.ready_o = (state_q == StIdle);
  assign bus.busy_o  = scan;
  assign bus.done_o  = (state_q == StDone);
  assign bus.ch_o    = scan ? sel : '0;

  demux_1to32 u_demux (
    .en_i   (scan),
    .data_i (data_q),
    .sel_i  (sel),
    .out_o  (bus.out_o)
  );

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl: directed vectors, corner sequences and
// randomized scans compared every cycle against a queue-based channel schedule model.
module tb_demux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_scan_ctrl_if #(.DWELL_W(4)) bus ();

  demux_scan_ctrl #(
    .NUM_CH  (32),
    .DWELL_W (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: queue of channels, one entry per expected SCAN cycle; front = current cycle.
  int q[$];
  bit m_done;
  bit m_data;

  int busy_cnt;
  int done_cnt;
  int first_ch;

  typedef struct {
    logic [31:0] mask;
    bit          data;
    int          dwell;
    int          exp_scan;
    int          exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_done = 1'b0;
    m_data = 1'b0;
  endfunction

  function automatic void model_step(input bit start, input logic [31:0] mask, input bit data,
                                     input int dwell, input bit abort);
    if (m_done) begin
      m_done = 1'b0;
    end else if (q.size() > 0) begin
      if (abort) begin
        q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      m_data = data;
      for (int n = 0; n < 32; n++) begin
        if (mask[n]) begin
          for (int k = 0; k <= dwell; k++) q.push_back(n);
        end
      end
      if (q.size() == 0) m_done = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    logic        e_busy;
    logic [4:0]  e_ch;
    logic [31:0] e_out;
    e_busy = (q.size() > 0);
    e_ch   = e_busy ? 5'(q[0]) : 5'd0;
    e_out  = (e_busy && m_data) ? (32'd1 << e_ch) : 32'd0;
    chk("ready", {31'd0, bus.ready_o}, {31'd0, !e_busy && !m_done});
    chk("busy", {31'd0, bus.busy_o}, {31'd0, e_busy});
    chk("done", {31'd0, bus.done_o}, {31'd0, m_done});
    chk("ch", {27'd0, bus.ch_o}, {27'd0, e_ch});
    chk("out", bus.out_o, e_out);
    chk("onehot", {31'd0, ($countones(bus.out_o) <= 1)}, 32'd1);
    if (bus.busy_o === 1'b1) begin
      if (busy_cnt == 0) first_ch = int'(bus.ch_o);
      busy_cnt++;
    end
    if (bus.done_o === 1'b1) done_cnt++;
  endtask

  task automatic run_cycle(input bit start, input logic [31:0] mask, input bit data,
                           input int dwell, input bit abort);
    bus.start_i = start;
    bus.mask_i  = mask;
    bus.data_i  = data;
    bus.dwell_i = 4'(dwell);
    bus.abort_i = abort;
    @(posedge clk);
    model_step(start, mask, data, dwell, abort);
    #1;
    check_outputs();
  endtask

  function automatic bit model_active();
    return (q.size() > 0) || m_done;
  endfunction

  // Run until the model returns to IDLE, with noise on the request inputs.
  task automatic run_to_idle(input int budget, input string name);
    int cyc;
    cyc = 0;
    while (model_active() && cyc < budget) begin
      run_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), 1'b0);
      cyc++;
    end
    chk({name, "_term"}, {31'd0, cyc < budget}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 1'b1, 0, 1, 6};
    vecs[1] = '{32'h8000_4002, 1'b1, 2, 9, 1};
    vecs[2] = '{32'h0000_0000, 1'b1, 5, 0, 0};
    vecs[3] = '{32'h0000_000F, 1'b0, 1, 8, 0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 0, 32, 0};
    vecs[5] = '{32'h8000_0000, 1'b1, 15, 16, 31};

    bus.start_i = 1'b0;
    bus.mask_i  = '0;
    bus.data_i  = 1'b0;
    bus.dwell_i = '0;
    bus.abort_i = 1'b0;
    model_reset();
    busy_cnt = 0;
    done_cnt = 0;
    first_ch = 0;

    #1;
    check_outputs();
    #11;
    rst_n = 1'b1;

    // Table-driven scans; the first start lands on the first edge after reset release.
    foreach (vecs[i]) begin
      busy_cnt = 0;
      done_cnt = 0;
      run_cycle(1'b1, vecs[i].mask, vecs[i].data, vecs[i].dwell, 1'b0);
      run_to_idle(600, "vec");
      chk($sformatf("vec%0d_scan_len", i), busy_cnt, vecs[i].exp_scan);
      chk($sformatf("vec%0d_done_cnt", i), done_cnt, 1);
      if (vecs[i].exp_scan > 0) chk($sformatf("vec%0d_first_ch", i), first_ch, vecs[i].exp_first);
      run_cycle(1'b0, '0, 1'b0, 0, 1'b1);
    end

    // Abort on SCAN cycle 20 of a full-mask, max-dwell scan.
    done_cnt = 0;
    run_cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 15, 1'b0);
    for (int c = 1; c < 20; c++) run_cycle(1'b0, '0, 1'b0, 0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 0, 1'b1);
    chk("abort_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("abort_out", bus.out_o, 32'd0);
    run_cycle(1'b0, '0, 1'b0, 0, 1'b0);
    chk("abort_no_done", done_cnt, 0);

    // Abort coinciding with dwell completion of the last channel.
    done_cnt = 0;
    run_cycle(1'b1, 32'h0000_0001, 1'b1, 0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 0, 1'b1);
    run_cycle(1'b0, '0, 1'b0, 0, 1'b0);
    chk("abort_prio_no_done", done_cnt, 0);

    // Start pulsed mid-scan is ignored.
    busy_cnt = 0;
    run_cycle(1'b1, 32'h0000_000F, 1'b1, 1, 1'b0);
    run_cycle(1'b1, 32'h0000_0001, 1'b1, 0, 1'b0);
    run_cycle(1'b1, 32'h0000_0001, 1'b0, 7, 1'b0);
    run_to_idle(100, "busy_start");
    chk("busy_start_len", busy_cnt, 8);

    // Reset asserted mid-scan takes effect without a clock edge.
    done_cnt = 0;
    run_cycle(1'b1, 32'h0000_00FF, 1'b1, 3, 1'b0);
    repeat (5) run_cycle(1'b0, '0, 1'b0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", bus.out_o, 32'd0);
    chk("rst_async_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("rst_async_busy", {31'd0, bus.busy_o}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;
    repeat (3) run_cycle(1'b0, '0, 1'b0, 0, 1'b0);
    chk("rst_no_done", done_cnt, 0);

    // Randomized scans with optional abort and idle-time abort noise.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] m;
      int          dw;
      int          abort_at;
      int          cyc;
      m = $urandom;
      if ($urandom_range(0, 2) == 0) m = m & $urandom & $urandom;
      if ($urandom_range(0, 9) == 0) m = '0;
      dw = int'($urandom_range(0, 3));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      repeat ($urandom_range(0, 2)) run_cycle(1'b0, $urandom, 1'b1, 0, 1'($urandom_range(0, 1)));
      run_cycle(1'b1, m, 1'($urandom_range(0, 1)), dw, 1'b0);
      cyc = 0;
      while (model_active() && cyc < 600) begin
        cyc++;
        run_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), (cyc == abort_at));
      end
      chk("rand_term", {31'd0, cyc < 600}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
